// File: rtl/sample_log_writer_if.sv
// rtl/sample_log_writer_if.sv - RAM write-port bundle between the sample log writer and the on-chip RAM
// Ports (modport master = log writer, slave = RAM):
//   mem_address     word address, ADDR_W bits
//   mem_writedata   32-bit write data
//   mem_byteenable  byte lanes, always all four
//   mem_chipselect  asserted together with mem_write
//   mem_write       one-cycle write strobe
//   mem_clken       RAM clock enable, constant 1
interface sample_log_writer_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_writedata;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_clken;

    modport master (
        output mem_address,
        output mem_writedata,
        output mem_byteenable,
        output mem_chipselect,
        output mem_write,
        output mem_clken
    );

    modport slave (
        input mem_address,
        input mem_writedata,
        input mem_byteenable,
        input mem_chipselect,
        input mem_write,
        input mem_clken
    );
endinterface

// File: rtl/sample_log_writer.sv
// rtl/sample_log_writer.sv - captures free-running samples into a FIFO and writes them to RAM as a circular log
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              logging enabled while high
//   clear               pulse: zero-fill the RAM and restart the log at address 0
//   snk_valid/snk_data  sample strobe and word, no backpressure
//   mem                 RAM write port (sample_log_writer_if.master)
//   wr_ptr              next log address to be written
//   wrapped             sticky: the log has wrapped at least once
//   busy                high while zero-filling
//   drop_count          saturating count of samples lost to FIFO overflow
// Optional feature macro: SAMPLE_LOG_TIMESTAMP_EN (each sample logged as {timestamp, data}, two words)
module sample_log_writer #(
    parameter int DEPTH      = 75000,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 snk_valid,
    input  logic [31:0]          snk_data,
    sample_log_writer_if.master  mem,
    output logic [ADDR_W-1:0]    wr_ptr,
    output logic                 wrapped,
    output logic                 busy,
    output logic [15:0]          drop_count
);
    localparam int FW = $clog2(FIFO_DEPTH);
`ifdef SAMPLE_LOG_TIMESTAMP_EN
    localparam int ENTRY_W = 64;
`else
    localparam int ENTRY_W = 32;
`endif
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
    state_t state;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FW:0]        f_wp, f_rp;
    logic               f_empty, f_full;
    logic               flush, pop, push_req, push, drop;
    logic [ENTRY_W-1:0] head, entry;
    logic [ADDR_W-1:0]  clr_addr, ptr_next;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign f_empty  = (f_wp == f_rp);
    assign f_full   = (f_wp[FW] != f_rp[FW]) && (f_wp[FW-1:0] == f_rp[FW-1:0]);
    assign head     = fifo_mem[f_rp[FW-1:0]];
    // A clear seen in RUN discards everything queued, including a sample arriving that cycle.
    assign flush    = (state == RUN) && clear;
    assign push_req = snk_valid && (state != IDLE) && !flush;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push     = push_req && (!f_full || pop);
    assign drop     = push_req && f_full && !pop;
    assign ptr_next = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;

    assign mem.mem_byteenable = 4'hF;
    assign mem.mem_clken      = 1'b1;

`ifdef SAMPLE_LOG_TIMESTAMP_EN
    logic [31:0] cycle_count;
    logic        phase;   // 0: timestamp word next, 1: data word next (entry popped then)

    assign entry = {cycle_count, snk_data};
    assign pop   = (state == RUN) && !clear && !f_empty && phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
        end
    end
`else
    assign entry = snk_data;
    assign pop   = (state == RUN) && !clear && !f_empty;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[f_wp[FW-1:0]] <= entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_wp       <= '0;
            f_rp       <= '0;
            drop_count <= '0;
        end else begin
            if (flush) begin
                f_rp <= f_wp;
            end else if (pop) begin
                f_rp <= f_rp + 1'b1;
            end
            if (push) begin
                f_wp <= f_wp + 1'b1;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            busy               <= 1'b0;
            wr_ptr             <= '0;
            wrapped            <= 1'b0;
            clr_addr           <= '0;
            mem.mem_write      <= 1'b0;
            mem.mem_chipselect <= 1'b0;
            mem.mem_address    <= '0;
            mem.mem_writedata  <= '0;
`ifdef SAMPLE_LOG_TIMESTAMP_EN
            phase              <= 1'b0;
`endif
        end else begin
            mem.mem_write      <= 1'b0;
            mem.mem_chipselect <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        clr_addr <= '0;
                    end else if (enable) begin
                        state <= RUN;
                    end
                end
                CLEAR: begin
                    mem.mem_write      <= 1'b1;
                    mem.mem_chipselect <= 1'b1;
                    mem.mem_address    <= clr_addr;
                    mem.mem_writedata  <= '0;
                    if (clear) begin
                        clr_addr <= '0;
                    end else if (clr_addr == LAST) begin
                        wr_ptr  <= '0;
                        wrapped <= 1'b0;
                        busy    <= 1'b0;
                        state   <= enable ? RUN : IDLE;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                RUN: begin
                    if (clear) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        clr_addr <= '0;
`ifdef SAMPLE_LOG_TIMESTAMP_EN
                        phase    <= 1'b0;
`endif
                    end else if (!f_empty) begin
                        mem.mem_write      <= 1'b1;
                        mem.mem_chipselect <= 1'b1;
                        mem.mem_address    <= wr_ptr;
                        wr_ptr             <= ptr_next;
                        if (wr_ptr == LAST) begin
                            wrapped <= 1'b1;
                        end
`ifdef SAMPLE_LOG_TIMESTAMP_EN
                        mem.mem_writedata <= phase ? head[31:0] : head[63:32];
                        phase             <= !phase;
`else
                        mem.mem_writedata <= head;
`endif
                    end else if (!enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_log_writer.sv
// tb/tb_sample_log_writer.sv - self-checking bench for sample_log_writer against a queue-based log model
module tb_sample_log_writer;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int FD     = 4;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              enable    = 1'b0;
    logic              clear     = 1'b0;
    logic              snk_valid = 1'b0;
    logic [31:0]       snk_data  = '0;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wrapped;
    logic              busy;
    logic [15:0]       drop_count;

    sample_log_writer_if #(.ADDR_W(ADDR_W)) mem_if ();

    sample_log_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (clear),
        .snk_valid  (snk_valid),
        .snk_data   (snk_data),
        .mem        (mem_if.master),
        .wr_ptr     (wr_ptr),
        .wrapped    (wrapped),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_bad  = 0;
    int cs_bad = 0;
    logic [63:0] got_q [$];
    logic [63:0] exp_q [$];

    // Reference log: 0 idle, 1 zero-filling, 2 logging; the FIFO is a plain queue.
    int          m_state;
    logic [31:0] m_q [$];
    int          m_ptr, m_fill, m_drops;
    bit          m_wrapped;

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_if.mem_write) got_q.push_back({32'(mem_if.mem_address), mem_if.mem_writedata});
            if (mem_if.mem_chipselect !== mem_if.mem_write) cs_bad++;
        end
    end

    task automatic model_reset();
        m_state = 0; m_q.delete(); m_ptr = 0; m_fill = 0; m_drops = 0; m_wrapped = 0;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic model_step(input bit en, input bit cl, input bit v, input logic [31:0] d);
        int st0; int sz0; bit pop; bit blocked;
        st0 = m_state; sz0 = m_q.size();
        pop = (st0 == 2) && !cl && (sz0 > 0);
        blocked = (st0 == 2) && cl;
        case (st0)
            0: if (cl) begin m_state = 1; m_fill = 0; end else if (en) m_state = 2;
            1: begin
                exp_q.push_back({32'(m_fill), 32'h0});
                if (cl) m_fill = 0;
                else if (m_fill == DEPTH - 1) begin m_ptr = 0; m_wrapped = 0; m_state = en ? 2 : 0; end
                else m_fill++;
            end
            default: begin
                if (cl) begin m_q.delete(); m_state = 1; m_fill = 0; end
                else if (pop) begin
                    exp_q.push_back({32'(m_ptr), m_q.pop_front()});
                    m_ptr = (m_ptr + 1) % DEPTH;
                    if (m_ptr == 0) m_wrapped = 1;
                end
                else if (!en) m_state = 0;
            end
        endcase
        if (v && st0 != 0 && !blocked) begin
            if (sz0 < FD || pop) m_q.push_back(d);
            else if (m_drops < 65535) m_drops++;
        end
    endtask

    task automatic drive(input bit en, input bit cl, input bit v, input logic [31:0] d);
        @(negedge clk);
        enable = en; clear = cl; snk_valid = v; snk_data = d;
        model_step(en, cl, v, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; snk_valid = 1'b0; snk_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (mem_if.mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b expected 0", mem_if.mem_write); end
        n_vec++; if (mem_if.mem_chipselect !== 1'b0) begin n_bad++; $display("FAIL reset_cs: got %b expected 0", mem_if.mem_chipselect); end
        n_vec++; if (mem_if.mem_address !== '0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", mem_if.mem_address); end
        n_vec++; if (wr_ptr !== '0) begin n_bad++; $display("FAIL reset_wr_ptr: got %h expected 0", wr_ptr); end
        n_vec++; if (wrapped !== 1'b0) begin n_bad++; $display("FAIL reset_wrapped: got %b expected 0", wrapped); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (drop_count !== 16'h0) begin n_bad++; $display("FAIL reset_drops: got %h expected 0", drop_count); end
        n_vec++; if (mem_if.mem_byteenable !== 4'hF) begin n_bad++; $display("FAIL byteenable: got %h expected f", mem_if.mem_byteenable); end
        n_vec++; if (mem_if.mem_clken !== 1'b1) begin n_bad++; $display("FAIL clken: got %b expected 1", mem_if.mem_clken); end
    endtask

`ifndef SAMPLE_LOG_TIMESTAMP_EN
    task automatic test_basic();
        logic [63:0] want [3];
        want[0] = {32'd0, 32'hA1}; want[1] = {32'd1, 32'hA2}; want[2] = {32'd2, 32'hA3};
        do_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 1, 32'hA1);
        drive(1, 0, 1, 32'hA2);
        n_vec++; if (mem_if.mem_write !== 1'b0) begin n_bad++; $display("FAIL basic_early_write: got %b expected 0", mem_if.mem_write); end
        drive(1, 0, 1, 32'hA3);
        n_vec++; if ({mem_if.mem_write, 29'(mem_if.mem_address), mem_if.mem_writedata} !== {1'b1, 29'd0, 32'hA1})
            begin n_bad++; $display("FAIL basic_latency: got w=%b a=%h d=%h expected w=1 a=0 d=a1", mem_if.mem_write, mem_if.mem_address, mem_if.mem_writedata); end
        repeat (3) drive(1, 0, 0, 0);
        @(negedge clk); #1;
        n_vec++; if (got_q.size() != 3) begin n_bad++; $display("FAIL basic_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== want[i]) begin n_bad++; $display("FAIL basic_write%0d: got %h expected %h", i, got_q[i], want[i]); end
        end
        n_vec++; if (wr_ptr !== 3'd3) begin n_bad++; $display("FAIL basic_wr_ptr: got %0d expected 3", wr_ptr); end
        n_vec++; if (wrapped !== 1'b0) begin n_bad++; $display("FAIL basic_wrapped: got %b expected 0", wrapped); end
        n_vec++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL basic_drops: got %0d expected 0", drop_count); end
        n_vec++; if (cs_bad != 0) begin n_bad++; $display("FAIL chipselect_pairing: got %0d mismatched cycles expected 0", cs_bad); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            drive(1, 0, 1, 32'(i));
            if (i == 9) begin n_vec++; if (wrapped !== 1'b0) begin n_bad++; $display("FAIL wrap_early: got %b expected 0", wrapped); end end
            if (i == 10) begin n_vec++; if (wrapped !== 1'b1) begin n_bad++; $display("FAIL wrap_at_8th: got %b expected 1", wrapped); end end
        end
        repeat (3) drive(1, 0, 0, 0);
        @(negedge clk); #1;
        n_vec++; if (got_q.size() != 10) begin n_bad++; $display("FAIL wrap_count: got %0d expected 10", got_q.size()); end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== {32'(i % 8), 32'(i + 1)}) begin n_bad++; $display("FAIL wrap_write%0d: got %h expected %h", i, got_q[i], {32'(i % 8), 32'(i + 1)}); end
        end
        n_vec++; if (wr_ptr !== 3'd2) begin n_bad++; $display("FAIL wrap_wr_ptr: got %0d expected 2", wr_ptr); end
        n_vec++; if (wrapped !== 1'b1) begin n_bad++; $display("FAIL wrap_sticky: got %b expected 1", wrapped); end
    endtask

    task automatic test_clear_overflow();
        logic [31:0] kept [6];
        kept[0] = 200; kept[1] = 201; kept[2] = 202; kept[3] = 203; kept[4] = 208; kept[5] = 209;
        do_reset();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 32'(100 + i));
        repeat (3) drive(1, 0, 0, 0);
        n_vec++; if (wr_ptr !== 3'd5) begin n_bad++; $display("FAIL clr_pre_wr_ptr: got %0d expected 5", wr_ptr); end
        #1; got_q.delete();
        drive(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 1, 32'(200 + i));
            if (i == 0) begin n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy: got %b expected 1", busy); end end
        end
        repeat (10) drive(1, 0, 0, 0);
        @(negedge clk); #1;
        n_vec++; if (got_q.size() != 14) begin n_bad++; $display("FAIL clr_count: got %0d expected 14", got_q.size()); end
        for (int i = 0; i < 14 && i < got_q.size(); i++) begin
            logic [63:0] w;
            w = (i < 8) ? {32'(i), 32'h0} : {32'(i - 8), kept[i - 8]};
            n_vec++; if (got_q[i] !== w) begin n_bad++; $display("FAIL clr_write%0d: got %h expected %h", i, got_q[i], w); end
        end
        n_vec++; if (drop_count !== 16'd4) begin n_bad++; $display("FAIL clr_drops: got %0d expected 4", drop_count); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy_end: got %b expected 0", busy); end
        n_vec++; if (wr_ptr !== 3'd6) begin n_bad++; $display("FAIL clr_wr_ptr: got %0d expected 6", wr_ptr); end
    endtask

    task automatic test_drain();
        do_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 1, 32'h300);
        drive(0, 0, 1, 32'h301);
        drive(0, 0, 1, 32'h302);
        repeat (4) drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 32'h400 + 32'(i));
        repeat (3) drive(0, 0, 0, 0);
        @(negedge clk); #1;
        n_vec++; if (got_q.size() != 3) begin n_bad++; $display("FAIL drain_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== {32'(i), 32'h300 + 32'(i)}) begin n_bad++; $display("FAIL drain_write%0d: got %h expected %h", i, got_q[i], {32'(i), 32'h300 + 32'(i)}); end
        end
        n_vec++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL drain_drops: got %0d expected 0", drop_count); end
        n_vec++; if (wr_ptr !== 3'd3) begin n_bad++; $display("FAIL drain_wr_ptr: got %0d expected 3", wr_ptr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(1, 0, 1, 32'h500 + 32'(i));
        n_vec++; if (mem_if.mem_write !== 1'b1) begin n_bad++; $display("FAIL arst_pre_write: got %b expected 1", mem_if.mem_write); end
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (mem_if.mem_write !== 1'b0) begin n_bad++; $display("FAIL arst_write: got %b expected 0", mem_if.mem_write); end
        n_vec++; if (wr_ptr !== '0) begin n_bad++; $display("FAIL arst_wr_ptr: got %0d expected 0", wr_ptr); end
        n_vec++; if (wrapped !== 1'b0) begin n_bad++; $display("FAIL arst_wrapped: got %b expected 0", wrapped); end
        n_vec++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL arst_drops: got %0d expected 0", drop_count); end
        enable = 1'b0; snk_valid = 1'b0;
        model_reset();
        @(negedge clk); reset_n = 1'b1;
        drive(1, 0, 0, 0);
        drive(1, 0, 1, 32'h600);
        repeat (4) drive(1, 0, 0, 0);
        @(negedge clk); #1;
        n_vec++; if (got_q.size() != 1) begin n_bad++; $display("FAIL arst_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_vec++; if (got_q[0] !== {32'd0, 32'h600}) begin n_bad++; $display("FAIL arst_first: got %h expected %h", got_q[0], {32'd0, 32'h600}); end
        end
    endtask

    task automatic test_random();
        bit en; bit cl; bit v;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) < 7);
            drive(en, cl, v, $urandom);
        end
        repeat (20) drive(1, 0, 0, 0);
        @(negedge clk); #1;
        n_vec++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_write%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (wr_ptr !== ADDR_W'(m_ptr)) begin n_bad++; $display("FAIL rand_wr_ptr: got %0d expected %0d", wr_ptr, m_ptr); end
        n_vec++; if (wrapped !== m_wrapped) begin n_bad++; $display("FAIL rand_wrapped: got %b expected %b", wrapped, m_wrapped); end
        n_vec++; if (drop_count !== 16'(m_drops)) begin n_bad++; $display("FAIL rand_drops: got %0d expected %0d", drop_count, m_drops); end
        n_vec++; if (busy !== (m_state == 1)) begin n_bad++; $display("FAIL rand_busy: got %b expected %b", busy, m_state == 1); end
    endtask
`else
    task automatic test_timestamp();
        do_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 1, 32'hD0);
        repeat (2) drive(1, 0, 0, 0);
        drive(1, 0, 1, 32'hD1);
        repeat (6) drive(1, 0, 0, 0);
        @(negedge clk); #1;
        n_vec++; if (got_q.size() != 4) begin n_bad++; $display("FAIL ts_count: got %0d expected 4", got_q.size()); end
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (got_q[i][63:32] !== 32'(i)) begin n_bad++; $display("FAIL ts_addr%0d: got %0d expected %0d", i, got_q[i][63:32], i); end
            end
            n_vec++; if (got_q[1][31:0] !== 32'hD0) begin n_bad++; $display("FAIL ts_d0: got %h expected d0", got_q[1][31:0]); end
            n_vec++; if (got_q[3][31:0] !== 32'hD1) begin n_bad++; $display("FAIL ts_d1: got %h expected d1", got_q[3][31:0]); end
            n_vec++; if (got_q[2][31:0] - got_q[0][31:0] !== 32'd3) begin n_bad++; $display("FAIL ts_delta: got %0d expected 3", got_q[2][31:0] - got_q[0][31:0]); end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
`ifndef SAMPLE_LOG_TIMESTAMP_EN
        test_basic();
        test_wrap();
        test_clear_overflow();
        test_drain();
        test_async_reset();
        test_random();
`else
        test_timestamp();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
